// File: rtl/proc_defs.sv
// Shared definitions for the processor, its instruction-memory loader and the bench.
package proc_defs;

  localparam int DATA_W      = 32;
  localparam int IMEM_ADDR_W = 4;

  // Loader sequencing: wait for a request, stream words in, hold the core, let it run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader. It takes a valid/ready word stream and writes it
// into imem from address 0. The core stays in reset while loading, and for HOLD_CYCLES
// cycles after the final word, so the last write has landed before the core runs.
module imem_program_loader
  import proc_defs::loader_state_t;
  import proc_defs::IDLE;
  import proc_defs::LOAD;
  import proc_defs::HOLD;
  import proc_defs::RUN;
#(
  parameter int DATA_W      = proc_defs::DATA_W,
  parameter int ADDR_W      = proc_defs::IMEM_ADDR_W,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err_overflow
);

  // The hold counter only needs to reach HOLD_CYCLES-1.
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  loader_state_t     state;
  logic [ADDR_W-1:0] wptr;
  logic [HC_W-1:0]   hold_cnt;
  logic              xfer;

  // Handshake and status decode straight from the state register.
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state == LOAD) || (state == HOLD);
    xfer     = in_valid && (state == LOAD);
  end

  // Loader FSM, write pointer, hold counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      core_reset   <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      wptr         <= '0;
      hold_cnt     <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          core_reset <= 1'b1;
          if (load_start) begin
            state        <= LOAD;
            wptr         <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        LOAD: begin
          core_reset <= 1'b1;
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= wptr;
            imem_wdata <= in_data;
            if (in_last) begin
              wptr     <= wptr + ADDR_W'(1);
              state    <= HOLD;
              hold_cnt <= '0;
            end else if (wptr == {ADDR_W{1'b1}}) begin
              // Memory is full and no end marker: keep the pointer parked, abort.
              err_overflow <= 1'b1;
              state        <= IDLE;
            end else begin
              wptr <= wptr + ADDR_W'(1);
            end
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + HC_W'(1);
          if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            done       <= 1'b1;
          end else begin
            core_reset <= 1'b1;
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
          end else begin
            core_reset <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for the imem program loader with a small imem model on the write port.
module tb_imem_program_loader;
  import proc_defs::*;

  localparam int AW     = IMEM_ADDR_W;
  localparam int DEPTH  = 2 ** AW;
  localparam int HOLD_N = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              imem_we;
  logic [AW-1:0]     imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              err_overflow;

  logic [DATA_W-1:0] mem [DEPTH];
  int                we_cnt = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  int                base;

  imem_program_loader #(
    .DATA_W(DATA_W), .ADDR_W(AW), .HOLD_CYCLES(HOLD_N)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // imem model: capture writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word transferred at the next edge; the write must appear right after it.
  task automatic xfer(input logic [DATA_W-1:0] d, input logic last, input int addr);
    chk("in_ready_before_xfer", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("we_after_xfer", imem_we, 1);
    chk("addr_after_xfer", imem_addr, addr);
    chk("wdata_after_xfer", imem_wdata, d);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1: reset, then idle
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals("t1");
    tick(); tick(); tick();
    chk("t1_idle_core_reset", core_reset, 1);
    chk("t1_no_writes", we_cnt, 0);

    // 2: three-word program, continuous valid
    pulse_start();
    chk("t2_in_ready", in_ready, 1);
    chk("t2_busy", busy, 1);
    base = we_cnt;
    xfer(32'h0000_0013, 1'b0, 0);
    xfer(32'h0010_0093, 1'b0, 1);
    xfer(32'h0020_0113, 1'b1, 2);
    chk("t2_hold_in_ready", in_ready, 0);
    chk("t2_hold_core_reset0", core_reset, 1);
    tick();
    chk("t2_hold_core_reset1", core_reset, 1);
    chk("t2_hold_done", done, 0);
    chk("t2_hold_we", imem_we, 0);
    tick();
    chk("t2_release", core_reset, 0);
    chk("t2_done", done, 1);
    chk("t2_busy_run", busy, 0);
    chk("t2_mem0", mem[0], 32'h0000_0013);
    chk("t2_mem1", mem[1], 32'h0010_0093);
    chk("t2_mem2", mem[2], 32'h0020_0113);
    chk("t2_we_count", we_cnt - base, 3);

    // 3 and 6a: reload from RUN with gaps between words
    for (int i = 0; i < 3; i++) mem[i] = '0;
    pulse_start();
    chk("t3_core_reset", core_reset, 1);
    chk("t3_done_cleared", done, 0);
    base = we_cnt;
    xfer(32'h0000_0013, 1'b0, 0);
    tick(); chk("t3_gap_we0", imem_we, 0);
    tick(); chk("t3_gap_we1", imem_we, 0);
    xfer(32'h0010_0093, 1'b0, 1);
    tick(); tick();
    xfer(32'h0020_0113, 1'b1, 2);
    tick(); tick();
    chk("t3_done", done, 1);
    chk("t3_release", core_reset, 0);
    chk("t3_mem0", mem[0], 32'h0000_0013);
    chk("t3_mem1", mem[1], 32'h0010_0093);
    chk("t3_mem2", mem[2], 32'h0020_0113);
    chk("t3_we_count", we_cnt - base, 3);

    // 4: overflow, DEPTH words with no end marker
    pulse_start();
    base = we_cnt;
    for (int i = 0; i < DEPTH; i++) xfer(32'hA000_0000 + i, 1'b0, i);
    chk("t4_err", err_overflow, 1);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_core_reset", core_reset, 1);
    chk("t4_done", done, 0);
    tick(); tick(); tick();
    chk("t4_stays_reset", core_reset, 1);
    chk("t4_stays_idle", busy, 0);
    chk("t4_we_count", we_cnt - base, DEPTH);
    chk("t4_mem15", mem[DEPTH-1], 32'hA000_0000 + DEPTH - 1);
    chk("t4_mem0", mem[0], 32'hA000_0000);

    // 5: reset mid-load, reset wins over load_start, then a full load
    pulse_start();
    chk("t5_err_cleared", err_overflow, 0);
    xfer(32'h1111_1111, 1'b0, 0);
    xfer(32'h2222_2222, 1'b0, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_rst");
    load_start = 1'b1;
    tick();
    load_start = 1'b0; reset = 1'b0;
    chk("t5_start_with_reset", in_ready, 0);
    pulse_start();
    xfer(32'h0000_0011, 1'b0, 0);
    xfer(32'h0000_0022, 1'b0, 1);
    xfer(32'h0000_0033, 1'b1, 2);
    tick(); tick();
    chk("t5_done", done, 1);
    chk("t5_release", core_reset, 0);
    chk("t5_mem2", mem[2], 32'h0000_0033);

    // 6: single-word reload from RUN; load_start in HOLD is ignored
    pulse_start();
    chk("t6_core_reset", core_reset, 1);
    chk("t6_done_cleared", done, 0);
    xfer(32'hDEAD_BEEF, 1'b1, 0);
    pulse_start();
    chk("t6_hold_ignores_start", in_ready, 0);
    chk("t6_hold_core_reset", core_reset, 1);
    tick();
    chk("t6_release", core_reset, 0);
    chk("t6_done", done, 1);
    chk("t6_mem0", mem[0], 32'hDEAD_BEEF);
    chk("t6_mem1_kept", mem[1], 32'h0000_0022);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
